temperature_scan_calc: RTL and testbench

- Multi-channel, sequential successor to the combinational temperature calculator.
- On a start command, snapshots CH channels of (factoryBaseTemp, factoryTempCoef, tempSensorValue).
- For each channel in turn, computes temperature = base + coef × sensor with one shared shift-add multiplier, saturating to TEMP_W bits.
- Streams per-channel results out over a valid/ready handshake, channel 0 first, and flags completion of the scan.

---
 rtl/temperature_scan_calc_pkg.sv | 32 +++
 rtl/temperature_scan_calc_if.sv | 47 ++++
 rtl/temperature_scan_calc_mul.sv | 37 +++
 rtl/temperature_scan_calc.sv | 135 +++++++++++++
 tb/tb_temperature_scan_calc.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/temperature_scan_calc_pkg.sv
// rtl/temperature_scan_calc_pkg.sv - FSM encoding, default widths and saturating add for the scan calculator
package temp_calc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_ADD,
        S_OUT,
        S_DONE
    } state_t;

    localparam int DEF_CH       = 4;
    localparam int DEF_TEMP_W   = 8;
    localparam int DEF_COEF_W   = 4;
    localparam int DEF_SENSOR_W = 4;
    localparam int SAT_W        = 32;

    // Returns {saturated, result}; result is clipped to tempW bits of all-ones
    function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] base,
                                               input logic [SAT_W-1:0] prod,
                                               input int unsigned      tempW);
        logic [SAT_W:0] sum;
        logic [SAT_W:0] maxVal;
        sum    = {1'b0, base} + {1'b0, prod};
        maxVal = ({{SAT_W{1'b0}}, 1'b1} << tempW) - {{SAT_W{1'b0}}, 1'b1};
        if (sum > maxVal) begin
            return {1'b1, maxVal[SAT_W-1:0]};
        end
        return {1'b0, sum[SAT_W-1:0]};
    endfunction

endpackage

// File: rtl/temperature_scan_calc_if.sv
// rtl/temperature_scan_calc_if.sv - scan command/result bundle; alarm signals exist only with TEMP_ALARM_EN
interface temperature_scan_calc_if
    import temp_calc_pkg::*;
#(
    parameter int CH       = DEF_CH,
    parameter int TEMP_W   = DEF_TEMP_W,
    parameter int COEF_W   = DEF_COEF_W,
    parameter int SENSOR_W = DEF_SENSOR_W
);
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    logic                   start;
    logic [CH*TEMP_W-1:0]   factoryBaseTemp;
    logic [CH*COEF_W-1:0]   factoryTempCoef;
    logic [CH*SENSOR_W-1:0] tempSensorValue;
    logic                   outReady;
    logic                   tempValid;
    logic [TEMP_W-1:0]      temperature;
    logic [CH_W-1:0]        tempChannel;
    logic                   saturated;
    logic                   busy;
    logic                   done;
`ifdef TEMP_ALARM_EN
    logic [TEMP_W-1:0]      alarmThreshold;
    logic                   alarm;
    logic [CH_W-1:0]        alarmChannel;

    modport master (
        output start, factoryBaseTemp, factoryTempCoef, tempSensorValue, outReady, alarmThreshold,
        input  tempValid, temperature, tempChannel, saturated, busy, done, alarm, alarmChannel
    );
    modport slave (
        input  start, factoryBaseTemp, factoryTempCoef, tempSensorValue, outReady, alarmThreshold,
        output tempValid, temperature, tempChannel, saturated, busy, done, alarm, alarmChannel
    );
`else
    modport master (
        output start, factoryBaseTemp, factoryTempCoef, tempSensorValue, outReady,
        input  tempValid, temperature, tempChannel, saturated, busy, done
    );
    modport slave (
        input  start, factoryBaseTemp, factoryTempCoef, tempSensorValue, outReady,
        output tempValid, temperature, tempChannel, saturated, busy, done
    );
`endif

endinterface

// File: rtl/temperature_scan_calc_mul.sv
// rtl/temperature_scan_calc_mul.sv - iterative unsigned shift-add multiplier, one sensor bit per step
module temp_shift_add_mul #(
    parameter int COEF_W   = 4,
    parameter int SENSOR_W = 4,
    parameter int PROD_W   = COEF_W + SENSOR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [COEF_W-1:0]   coef,
    input  logic [SENSOR_W-1:0] sensor,
    output logic [PROD_W-1:0]   product,
    output logic                last
);
    localparam int BIT_W = (SENSOR_W > 1) ? $clog2(SENSOR_W) : 1;

    logic [BIT_W-1:0] bitIdx;

    assign last = (bitIdx == BIT_W'(SENSOR_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
            bitIdx  <= '0;
        end else if (load) begin
            product <= '0;
            bitIdx  <= '0;
        end else if (step) begin
            if (sensor[bitIdx]) begin
                product <= product + (PROD_W'(coef) << bitIdx);
            end
            bitIdx <= last ? '0 : bitIdx + 1'b1;
        end
    end

endmodule

// File: rtl/temperature_scan_calc.sv
// rtl/temperature_scan_calc.sv - sequential multi-channel base+coef*sensor scan; TEMP_ALARM_EN adds a sticky threshold alarm
module temperature_scan_calc
    import temp_calc_pkg::*;
#(
    parameter int CH       = DEF_CH,
    parameter int TEMP_W   = DEF_TEMP_W,
    parameter int COEF_W   = DEF_COEF_W,
    parameter int SENSOR_W = DEF_SENSOR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    temperature_scan_calc_if.slave  bus
);
    localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
    localparam int PROD_W = COEF_W + SENSOR_W;

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic [TEMP_W-1:0]   baseSnap   [CH];
    logic [COEF_W-1:0]   coefSnap   [CH];
    logic [SENSOR_W-1:0] sensorSnap [CH];

    logic              load;
    logic              step;
    logic              last;
    logic              accept;
    logic              lastCh;
    logic [PROD_W-1:0] product;
    logic [SAT_W:0]    satRes;

    assign step   = (state == S_MUL);
    assign accept = (state == S_OUT) && bus.outReady;
    assign lastCh = (ch == CH_W'(CH - 1));
    assign load   = ((state == S_IDLE) && bus.start) || (accept && !lastCh);

    always_comb begin
        satRes = sat_add(SAT_W'(baseSnap[ch]), SAT_W'(product), TEMP_W);
    end

    temp_shift_add_mul #(
        .COEF_W   (COEF_W),
        .SENSOR_W (SENSOR_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .coef    (coefSnap[ch]),
        .sensor  (sensorSnap[ch]),
        .product (product),
        .last    (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            ch              <= '0;
            bus.tempValid   <= 1'b0;
            bus.temperature <= '0;
            bus.tempChannel <= '0;
            bus.saturated   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                baseSnap[i]   <= '0;
                coefSnap[i]   <= '0;
                sensorSnap[i] <= '0;
            end
`ifdef TEMP_ALARM_EN
            bus.alarm        <= 1'b0;
            bus.alarmChannel <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < CH; i++) begin
                            baseSnap[i]   <= bus.factoryBaseTemp[i*TEMP_W +: TEMP_W];
                            coefSnap[i]   <= bus.factoryTempCoef[i*COEF_W +: COEF_W];
                            sensorSnap[i] <= bus.tempSensorValue[i*SENSOR_W +: SENSOR_W];
                        end
                        ch       <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_MUL;
`ifdef TEMP_ALARM_EN
                        bus.alarm        <= 1'b0;
                        bus.alarmChannel <= '0;
`endif
                    end
                end
                S_MUL: begin
                    if (last) begin
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    bus.tempValid   <= 1'b1;
                    bus.temperature <= satRes[TEMP_W-1:0];
                    bus.saturated   <= satRes[SAT_W];
                    bus.tempChannel <= ch;
                    state           <= S_OUT;
`ifdef TEMP_ALARM_EN
                    // Only the first tripping channel of a scan is recorded
                    if (!bus.alarm && (satRes[TEMP_W-1:0] >= bus.alarmThreshold)) begin
                        bus.alarm        <= 1'b1;
                        bus.alarmChannel <= ch;
                    end
`endif
                end
                S_OUT: begin
                    if (bus.outReady) begin
                        bus.tempValid   <= 1'b0;
                        bus.temperature <= '0;
                        bus.tempChannel <= '0;
                        bus.saturated   <= 1'b0;
                        if (lastCh) begin
                            bus.done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            ch    <= ch + 1'b1;
                            state <= S_MUL;
                        end
                    end
                end
                S_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temperature_scan_calc.sv
// tb/tb_temperature_scan_calc.sv - scoreboard bench for temperature_scan_calc; TEMP_ALARM_EN enables alarm checks
module tb_temperature_scan_calc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    temperature_scan_calc_if bus ();
    temperature_scan_calc_if #(.CH(1)) bus1 ();

    temperature_scan_calc dut (.clk(clk), .rst(rst), .bus(bus));
    temperature_scan_calc #(.CH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        int t;
        int c;
        int s;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   doneCount = 0;
    int   doneBefore = 0;
    int   vb[4], vc[4], vs[4], et[4], es[4];
    int   expAlarmCh = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per accepted result
    always @(negedge clk) begin
        if (!rst && bus.tempValid && bus.outReady) begin
            if (q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("temperature", int'(bus.temperature), e.t);
                check("tempChannel", int'(bus.tempChannel), e.c);
                check("saturated", int'(bus.saturated), e.s);
            end
        end
        if (!rst && bus.done) doneCount++;
    end

    task automatic start_scan();
        int cnt;
        for (int i = 0; i < 4; i++) begin
            bus.factoryBaseTemp[i*8 +: 8] = 8'(vb[i]);
            bus.factoryTempCoef[i*4 +: 4] = 4'(vc[i]);
            bus.tempSensorValue[i*4 +: 4] = 4'(vs[i]);
            q.push_back('{t: et[i], c: i, s: es[i]});
        end
        doneBefore = doneCount;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
`ifdef TEMP_ALARM_EN
        check("alarm_cleared_on_start", int'(bus.alarm), 0);
`endif
        cnt = 0;
        while (cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (bus.tempValid) break;
        end
        check("first_valid_latency", cnt, 6);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (doneCount == doneBefore && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("done_pulse_count", doneCount, doneBefore + 1);
        check("queue_drained", q.size(), 0);
        @(posedge clk);
        #1 check("busy_after_done", int'(bus.busy), 0);
`ifdef TEMP_ALARM_EN
        check("alarm_set", int'(bus.alarm), 1);
        check("alarmChannel", int'(bus.alarmChannel), expAlarmCh);
`endif
    endtask

    initial begin
        int cnt;
        bus.start = 1'b0;
        bus.factoryBaseTemp = '0;
        bus.factoryTempCoef = '0;
        bus.tempSensorValue = '0;
        bus.outReady = 1'b1;
        bus1.start = 1'b0;
        bus1.factoryBaseTemp = 8'd0;
        bus1.factoryTempCoef = 4'd5;
        bus1.tempSensorValue = 4'd1;
        bus1.outReady = 1'b1;
`ifdef TEMP_ALARM_EN
        bus.alarmThreshold = 8'd50;
        bus1.alarmThreshold = 8'd50;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_tempValid", int'(bus.tempValid), 0);
        check("rst_temperature", int'(bus.temperature), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_ch1_tempValid", int'(bus1.tempValid), 0);
        rst = 1'b0;
        @(posedge clk);

        // Single-channel instance: 0 + 5*1
        #1 bus1.start = 1'b1;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        cnt = 0;
        while (cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (bus1.tempValid) break;
        end
        check("ch1_latency", cnt, 6);
        check("ch1_temperature", int'(bus1.temperature), 5);
        check("ch1_saturated", int'(bus1.saturated), 0);
        check("ch1_channel", int'(bus1.tempChannel), 0);
        @(negedge clk);
        check("ch1_done", int'(bus1.done), 1);
        check("ch1_valid_after_accept", int'(bus1.tempValid), 0);
        @(posedge clk);

        // Basic four-channel scan
        #1;
        vb = '{10, 20, 30, 40}; vc = '{1, 2, 3, 4}; vs = '{2, 3, 4, 5};
        et = '{12, 26, 42, 60}; es = '{0, 0, 0, 0};
        expAlarmCh = 3;
        start_scan();
        wait_done();

        // Saturation boundaries
        #1;
        vb = '{250, 30, 77, 200}; vc = '{15, 15, 0, 8}; vs = '{15, 15, 9, 7};
        et = '{255, 255, 77, 255}; es = '{1, 0, 0, 1};
        expAlarmCh = 0;
        start_scan();
        wait_done();

        // Zero sensor, max base, zero coef, large non-saturating sum
        #1;
        vb = '{0, 255, 100, 5}; vc = '{7, 1, 0, 15}; vs = '{0, 1, 5, 15};
        et = '{0, 255, 100, 230}; es = '{0, 1, 0, 0};
        expAlarmCh = 1;
        start_scan();
        wait_done();

        // Backpressure hold with ignored start and changed inputs
        #1;
        vb = '{10, 20, 30, 40}; vc = '{1, 2, 3, 4}; vs = '{2, 3, 4, 5};
        et = '{12, 26, 42, 60}; es = '{0, 0, 0, 0};
        expAlarmCh = 3;
        bus.outReady = 1'b0;
        start_scan();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) bus.start = 1'b1;
            if (k == 3) bus.start = 1'b0;
            if (k == 5) begin
                bus.factoryBaseTemp = '1;
                bus.factoryTempCoef = '1;
                bus.tempSensorValue = '1;
            end
            @(negedge clk);
            check("hold_stable", int'({bus.tempValid, bus.temperature, bus.tempChannel, bus.saturated}),
                  int'({1'b1, 8'd12, 2'd0, 1'b0}));
        end
        @(posedge clk);
        #1 bus.outReady = 1'b1;
        wait_done();

        // Reset during channel 2 multiply
        #1;
        vb = '{10, 20, 30, 40}; vc = '{1, 2, 3, 4}; vs = '{2, 3, 4, 5};
        et = '{12, 26, 42, 60}; es = '{0, 0, 0, 0};
        start_scan();
        cnt = 0;
        while (!(bus.tempValid && bus.tempChannel == 2'd1) && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        check("reached_channel1", int'(bus.tempChannel), 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_tempValid", int'(bus.tempValid), 0);
        check("midrst_temperature", int'(bus.temperature), 0);
        check("midrst_tempChannel", int'(bus.tempChannel), 0);
        check("midrst_saturated", int'(bus.saturated), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        q.delete();
        doneBefore = doneCount;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        check("no_done_after_rst", doneCount, doneBefore);
        #1;
        vb = '{0, 255, 100, 5}; vc = '{7, 1, 0, 15}; vs = '{0, 1, 5, 15};
        et = '{0, 255, 100, 230}; es = '{0, 1, 0, 0};
        expAlarmCh = 1;
        start_scan();
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
